d_cache_2way_wb: RTL and testbench

- Parametrised 2-way set-associative, write-back, write-allocate data cache between the pipeline MEM stage and line-wide data memory.
- Generalises the fixed 2-set/4-word D-cache in two ways: set count and line length are parameters, and dirty-victim writeback is implemented.
- Adds a full valid/ready handshake on both the CPU side and the memory side.
- Sits where the current D-cache sits; the I-cache is unaffected.

---
 rtl/d_cache_2way_wb_pkg.sv | 18 +
 rtl/d_cache_way_array.sv | 63 ++++++
 rtl/d_cache_2way_wb.sv | 146 ++++++++++++++
 tb/tb_d_cache_2way_wb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/d_cache_2way_wb_pkg.sv
// Shared types and defaults for the 2-way write-back D-cache.
package d_cache_2way_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL
  } state_e;

  localparam int DEF_WORD_W         = 16;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_SETS           = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/d_cache_way_array.sv
// One cache way: per-set tag/valid/dirty plus line storage, word-select read, word-merge write.
module d_cache_way_array #(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 2
) (
  input  logic                                                          clk_i,
  input  logic                                                          reset_i,
  input  logic [$clog2(SETS)-1:0]                                       idx_i,
  input  logic [$clog2(WORDS_PER_LINE)-1:0]                             off_i,
  input  logic                                                          wr_en_i,
  input  logic [WORD_W-1:0]                                             wr_word_i,
  input  logic                                                          fill_en_i,
  input  logic [WORD_W-$clog2(SETS)-$clog2(WORDS_PER_LINE)-1:0]         fill_tag_i,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]                              fill_line_i,
  output logic [WORD_W-$clog2(SETS)-$clog2(WORDS_PER_LINE)-1:0]         tag_o,
  output logic                                                          valid_o,
  output logic                                                          dirty_o,
  output logic [WORD_W-1:0]                                             word_o,
  output logic [WORD_W*WORDS_PER_LINE-1:0]                              line_o
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WORD_W - IDX_W - OFF_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic [LINE_W-1:0] data_q [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [OFF_W-1:0]  revOff;

  // Word 0 sits in the MSBs, so the slice position is the bit-inverted offset.
  assign revOff  = ~off_i;
  assign line_o  = data_q[idx_i];
  assign word_o  = line_o[revOff*WORD_W +: WORD_W];
  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      data_q[idx_i] <= fill_line_i;
      tag_q[idx_i]  <= fill_tag_i;
    end else if (wr_en_i) begin
      data_q[idx_i][revOff*WORD_W +: WORD_W] <= wr_word_i;
    end
  end

endmodule

// File: rtl/d_cache_2way_wb.sv
// 2-way set-associative write-back/write-allocate D-cache with LRU and dirty-victim writeback.
// Define DCACHE_STATS_EN to add saturating hit/miss/writeback counters.
module d_cache_2way_wb
  import d_cache_2way_wb_pkg::*;
#(
  parameter int WORD_W         = DEF_WORD_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int SETS           = DEF_SETS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cpu_read,
  input  logic                               cpu_write,
  input  logic [WORD_W-1:0]                  cpu_addr,
  input  logic [WORD_W-1:0]                  cpu_wdata,
  output logic [WORD_W-1:0]                  cpu_rdata,
  output logic                               cpu_ready,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [WORD_W-1:0]                  mem_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0]   mem_wdata,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]   mem_rdata,
  input  logic                               mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                        stat_hits,
  output logic [15:0]                        stat_misses,
  output logic [15:0]                        stat_writebacks
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WORD_W - IDX_W - OFF_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic [TAG_W-1:0]  addrTag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [TAG_W-1:0]  wayTag  [2];
  logic [WORD_W-1:0] wayWord [2];
  logic [LINE_W-1:0] wayLine [2];
  logic [1:0]        wayValid, wayDirty, wayHit, wordWr, fillEn;
  logic              req, hit, hitWay, victimSel, idle;

  state_e            state_q;
  logic              victim_q;
  logic [SETS-1:0]   lru_q;

  assign addrTag = cpu_addr[WORD_W-1 -: TAG_W];
  assign idx     = cpu_addr[OFF_W +: IDX_W];
  assign off     = cpu_addr[OFF_W-1:0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign wayHit[w] = wayValid[w] && (wayTag[w] == addrTag);
    assign wordWr[w] = idle && cpu_write && wayHit[w];
    assign fillEn[w] = (state_q == ST_FILL) && mem_ready && (victim_q == 1'(w));

    d_cache_way_array #(
      .WORD_W(WORD_W), .WORDS_PER_LINE(WORDS_PER_LINE), .SETS(SETS)
    ) u_way (
      .clk_i      (clk),
      .reset_i    (reset),
      .idx_i      (idx),
      .off_i      (off),
      .wr_en_i    (wordWr[w]),
      .wr_word_i  (cpu_wdata),
      .fill_en_i  (fillEn[w]),
      .fill_tag_i (addrTag),
      .fill_line_i(mem_rdata),
      .tag_o      (wayTag[w]),
      .valid_o    (wayValid[w]),
      .dirty_o    (wayDirty[w]),
      .word_o     (wayWord[w]),
      .line_o     (wayLine[w])
    );
  end

  assign req    = cpu_read | cpu_write;
  assign hit    = |wayHit;
  assign hitWay = ~wayHit[0];
  assign idle   = (state_q == ST_IDLE);

  // Invalid ways are filled before anything valid is evicted; otherwise the LRU bit names the victim.
  assign victimSel = !wayValid[0] ? 1'b0 : (!wayValid[1] ? 1'b1 : lru_q[idx]);

  assign cpu_ready = idle && (!req || hit);
  assign cpu_rdata = (idle && hit && cpu_read && !cpu_write) ? wayWord[hitWay] : '0;
  assign mem_write = (state_q == ST_WB);
  assign mem_read  = (state_q == ST_FILL);
  assign mem_wdata = mem_write ? wayLine[victim_q] : '0;

  always_comb begin
    mem_addr = '0;
    if (mem_write)     mem_addr = {wayTag[victim_q], idx, {OFF_W{1'b0}}};
    else if (mem_read) mem_addr = {addrTag, idx, {OFF_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req && hit) begin
            lru_q[idx] <= ~hitWay;
          end else if (req) begin
            victim_q <= victimSel;
            state_q  <= (wayValid[victimSel] && wayDirty[victimSel]) ? ST_WB : ST_FILL;
          end
        end
        ST_WB:   if (mem_ready) state_q <= ST_FILL;
        ST_FILL: begin
          if (mem_ready) begin
            lru_q[idx] <= ~victim_q;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (idle && req && hit)         hits_q   <= sat_inc16(hits_q);
      if (idle && req && !hit)        misses_q <= sat_inc16(misses_q);
      if (mem_write && mem_ready)     wbs_q    <= sat_inc16(wbs_q);
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_d_cache_2way_wb.sv
// Directed bench for d_cache_2way_wb with a line-memory model, read-data and writeback scoreboards.
module tb_d_cache_2way_wb;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, mem_read, mem_write, mem_ready;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_writebacks;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] rdQ [$];
  wb_t         wbQ [$];
  logic [63:0] memModel [logic [15:0]];

  d_cache_2way_wb dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lineOf(input logic [15:0] a);
    if (memModel.exists(a)) return memModel[a];
    return {4{a}};
  endfunction

  // Present one request and serve memory with the given latency until cpu_ready.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] expRdata, input int lat,
                               input int expCycles, input int expWrites);
    int cyc = 0, reads = 0, writes = 0, waitCnt = 0;
    logic done = 1'b0;
    logic [15:0] expData;
    wb_t cur;
    cur.addr = '0;
    cur.data = '0;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
    rdQ.push_back(expRdata);
    while (!done && cyc < 40) begin
      #1;
      cyc++;
      if (mem_read && mem_write) checkOutput({tag, "_memExcl"}, 1, 0);
      if (cpu_ready) begin
        expData = rdQ.pop_front();
        checkOutput({tag, "_rdata"}, cpu_rdata, expData);
        mem_ready = 1'b0;
        done = 1'b1;
      end else if (mem_write) begin
        if (waitCnt == 0) begin
          writes++;
          if (wbQ.size() > 0) cur = wbQ.pop_front();
          else checkOutput({tag, "_wbUnexpected"}, 1, 0);
        end
        checkOutput({tag, "_wbAddr"}, mem_addr, cur.addr);
        checkOutput({tag, "_wbData"}, mem_wdata, cur.data);
        mem_ready = (waitCnt >= lat);
        if (mem_ready) begin
          memModel[mem_addr] = mem_wdata;
          waitCnt = 0;
        end else waitCnt++;
      end else if (mem_read) begin
        if (waitCnt == 0) reads++;
        checkOutput({tag, "_fillAddr"}, mem_addr, {addr[15:2], 2'b00});
        mem_rdata = lineOf(mem_addr);
        mem_ready = (waitCnt >= lat);
        if (mem_ready) waitCnt = 0;
        else waitCnt++;
      end else begin
        mem_ready = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) begin
      checkOutput({tag, "_timeout"}, 1, 0);
      void'(rdQ.pop_front());
    end
    cpu_read = 1'b0; cpu_write = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    checkOutput({tag, "_cycles"}, 64'(cyc), 64'(expCycles));
    checkOutput({tag, "_memWrites"}, 64'(writes), 64'(expWrites));
    checkOutput({tag, "_memReads"}, 64'(reads), (expCycles > 1) ? 64'd1 : 64'd0);
  endtask

  function automatic wb_t mkWb(input logic [15:0] a, input logic [63:0] d);
    wb_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  initial begin
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    memModel[16'h0010] = 64'hAAAA_BBBB_CCCC_DDDD;
    memModel[16'h0020] = 64'h2020_2021_2022_2023;
    memModel[16'h0030] = 64'h3030_3031_3032_3033;
    memModel[16'h0044] = 64'h4440_4441_4442_4443;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_cpuReady", cpu_ready, 1);
    checkOutput("rst_cpuRdata", cpu_rdata, 0);
    checkOutput("rst_memRead", mem_read, 0);
    checkOutput("rst_memWrite", mem_write, 0);
    checkOutput("rst_memAddr", mem_addr, 0);
    checkOutput("rst_memWdata", mem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("coldRead",   1, 0, 16'h0010, 16'h0000, 16'hAAAA, 1, 4, 0);
    applyStimulus("writeHit",   0, 1, 16'h0011, 16'h1234, 16'h0000, 0, 1, 0);
    applyStimulus("readBack",   1, 0, 16'h0011, 16'h0000, 16'h1234, 0, 1, 0);
    applyStimulus("readW0",     1, 0, 16'h0010, 16'h0000, 16'hAAAA, 0, 1, 0);
    applyStimulus("fillWay1",   1, 0, 16'h0020, 16'h0000, 16'h2020, 0, 3, 0);
    applyStimulus("touch10",    1, 0, 16'h0010, 16'h0000, 16'hAAAA, 0, 1, 0);
    applyStimulus("lruVictim",  1, 0, 16'h0030, 16'h0000, 16'h3030, 0, 3, 0);
    applyStimulus("stillHit",   1, 0, 16'h0010, 16'h0000, 16'hAAAA, 0, 1, 0);
    applyStimulus("touch30",    1, 0, 16'h0031, 16'h0000, 16'h3031, 0, 1, 0);
    wbQ.push_back(mkWb(16'h0010, 64'hAAAA_1234_CCCC_DDDD));
    applyStimulus("dirtyEvict", 1, 0, 16'h0020, 16'h0000, 16'h2020, 0, 4, 1);
    applyStimulus("refetchWb",  1, 0, 16'h0011, 16'h0000, 16'h1234, 0, 3, 0);
    applyStimulus("writeMiss",  0, 1, 16'h0045, 16'h5555, 16'h0000, 2, 5, 0);
    applyStimulus("wmMerged",   1, 0, 16'h0045, 16'h0000, 16'h5555, 0, 1, 0);
    applyStimulus("wmRest",     1, 0, 16'h0046, 16'h0000, 16'h4442, 0, 1, 0);
    applyStimulus("set1Way1",   1, 0, 16'h004C, 16'h0000, 16'h004C, 0, 3, 0);
    wbQ.push_back(mkWb(16'h0044, 64'h4440_5555_4442_4443));
    applyStimulus("wmEvict",    1, 0, 16'h0054, 16'h0000, 16'h0054, 1, 6, 1);
    applyStimulus("rdWrBoth",   1, 1, 16'h004C, 16'h7777, 16'h0000, 0, 1, 0);
    applyStimulus("readBoth",   1, 0, 16'h004C, 16'h0000, 16'h7777, 0, 1, 0);

    cpu_read = 1'b1; cpu_addr = 16'h0060;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midFill_memRead", mem_read, 1);
    checkOutput("midFill_memAddr", mem_addr, 16'h0060);
    checkOutput("midFill_cpuReady", cpu_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstFill_memRead", mem_read, 0);
    checkOutput("rstFill_memWrite", mem_write, 0);
    reset = 1'b0; cpu_read = 1'b0;
    @(negedge clk);

    applyStimulus("postRst10",  1, 0, 16'h0011, 16'h0000, 16'h1234, 0, 3, 0);
    applyStimulus("postRst4C",  1, 0, 16'h004C, 16'h0000, 16'h004C, 0, 3, 0);
    checkOutput("wbQueueEmpty", 64'(wbQ.size()), 0);
`ifdef DCACHE_STATS_EN
    checkOutput("statHits", stat_hits, 2);
    checkOutput("statMisses", stat_misses, 2);
    checkOutput("statWritebacks", stat_writebacks, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
